// File: rtl/fx_eq_param_sched.sv
// EQ gain ramp scheduler: steps one band per sample tick toward its target,
// round-robin across the four bands, and announces each step over a req/ack handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no request outstanding; a sample tick may step one band
// ST_REQ   | coef_req held with band/value until the engine acknowledges
module fx_eq_param_sched #(
   parameter int unsigned PARAM_W   = 7,
   parameter int unsigned STEP      = 4,
   parameter int unsigned RESET_VAL = 64
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               sample_tick,
   input  logic [PARAM_W-1:0] low_tgt,
   input  logic [PARAM_W-1:0] mid_tgt,
   input  logic [PARAM_W-1:0] high_tgt,
   input  logic [PARAM_W-1:0] pres_tgt,
   output logic [PARAM_W-1:0] low_gain,
   output logic [PARAM_W-1:0] mid_gain,
   output logic [PARAM_W-1:0] high_gain,
   output logic [PARAM_W-1:0] presence,
   output logic               coef_req,
   output logic [1:0]         coef_band,
   output logic [PARAM_W-1:0] coef_val,
   input  logic               coef_ack,
   output logic               settled,
   output logic               overrun
);

   localparam logic [PARAM_W-1:0]        RESET_GAIN = PARAM_W'(RESET_VAL);
   localparam logic signed [PARAM_W:0]   STEP_S     = (PARAM_W+1)'(STEP);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [PARAM_W-1:0]   cur_q [4];
   logic [PARAM_W-1:0]   tgt   [4];
   logic [1:0]           rr_q, rr_d;

   logic                 req_d;
   logic [1:0]           band_d;
   logic [PARAM_W-1:0]   val_d;
   logic                 step_en;
   logic                 settled_d;
   logic                 overrun_d;

   logic                 found;
   logic [1:0]           sel;
   logic [1:0]           idx;
   logic signed [PARAM_W:0] diff;
   logic signed [PARAM_W:0] mag;
   logic signed [PARAM_W:0] delta;
   logic [PARAM_W-1:0]   new_val;
   logic                 all_eq;

   assign tgt[0] = low_tgt;
   assign tgt[1] = mid_tgt;
   assign tgt[2] = high_tgt;
   assign tgt[3] = pres_tgt;

   assign low_gain  = cur_q[0];
   assign mid_gain  = cur_q[1];
   assign high_gain = cur_q[2];
   assign presence  = cur_q[3];

   // First band off target, scanning from the round-robin pointer.
   always_comb begin
      found = 1'b0;
      sel   = rr_q;
      idx   = '0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_q + 2'(k);
         if (!found && (cur_q[idx] != tgt[idx])) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Bounded step toward target; the clamp to |diff| prevents overshoot and wrap.
   always_comb begin
      diff    = $signed({1'b0, tgt[sel]}) - $signed({1'b0, cur_q[sel]});
      mag     = (diff < 0) ? -diff : diff;
      delta   = (mag > STEP_S) ? STEP_S : mag;
      new_val = (diff < 0) ? (cur_q[sel] - delta[PARAM_W-1:0])
                           : (cur_q[sel] + delta[PARAM_W-1:0]);
   end

   always_comb begin
      all_eq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (cur_q[i] != tgt[i]) all_eq = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      req_d     = coef_req;
      band_d    = coef_band;
      val_d     = coef_val;
      step_en   = 1'b0;
      settled_d = (state_q == ST_IDLE) && all_eq;
      overrun_d = sample_tick && (state_q == ST_REQ);
      case (state_q)
         ST_IDLE: begin
            if (sample_tick && found) begin
               step_en = 1'b1;
               req_d   = 1'b1;
               band_d  = sel;
               val_d   = new_val;
               rr_d    = sel + 2'd1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (coef_ack) begin
               req_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         rr_q      <= '0;
         coef_req  <= 1'b0;
         coef_band <= '0;
         coef_val  <= '0;
         settled   <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         coef_req  <= req_d;
         coef_band <= band_d;
         coef_val  <= val_d;
         settled   <= settled_d;
         overrun   <= overrun_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) cur_q[i] <= RESET_GAIN;
      end else if (step_en) begin
         cur_q[sel] <= new_val;
      end
   end

endmodule

// File: tb/tb_fx_eq_param_sched.sv
// Bench for fx_eq_param_sched: directed ramp/round-robin/backpressure/reset scenarios
// followed by random traffic, all compared each cycle against an integer model.
module tb_fx_eq_param_sched;

   localparam int W    = 7;
   localparam int STEP = 4;
   localparam int RV   = 64;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         sample_tick = 1'b0;
   logic         coef_ack = 1'b0;
   logic [W-1:0] low_tgt = 7'd64, mid_tgt = 7'd64, high_tgt = 7'd64, pres_tgt = 7'd64;
   logic [W-1:0] low_gain, mid_gain, high_gain, presence;
   logic         coef_req, settled, overrun;
   logic [1:0]   coef_band;
   logic [W-1:0] coef_val;

   fx_eq_param_sched #(.PARAM_W(W), .STEP(STEP), .RESET_VAL(RV)) dut (
      .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
      .low_tgt(low_tgt), .mid_tgt(mid_tgt), .high_tgt(high_tgt), .pres_tgt(pres_tgt),
      .low_gain(low_gain), .mid_gain(mid_gain), .high_gain(high_gain), .presence(presence),
      .coef_req(coef_req), .coef_band(coef_band), .coef_val(coef_val),
      .coef_ack(coef_ack), .settled(settled), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Behavioural model: gains as plain integers, a busy flag for the outstanding request.
   int m_cur[4] = '{RV, RV, RV, RV};
   int m_rr = 0;
   bit m_req = 0, m_ovr = 0, m_set = 0;
   int m_band = 0, m_val = 0;
   int m_ovr_cnt = 0;
   int mt[4];
   bit m_all_eq;
   int m_b, m_d, m_j;
   int log_band[$];
   int log_val[$];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cur = '{RV, RV, RV, RV};
         m_rr = 0; m_req = 0; m_band = 0; m_val = 0; m_ovr = 0; m_set = 0;
      end else begin
         mt = '{int'(low_tgt), int'(mid_tgt), int'(high_tgt), int'(pres_tgt)};
         m_all_eq = 1;
         for (int i = 0; i < 4; i++) if (m_cur[i] != mt[i]) m_all_eq = 0;
         m_set = !m_req && m_all_eq;
         m_ovr = sample_tick && m_req;
         if (m_ovr) m_ovr_cnt++;
         if (m_req) begin
            if (coef_ack) m_req = 0;
         end else if (sample_tick) begin
            m_b = -1;
            for (int k = 0; k < 4; k++) begin
               m_j = (m_rr + k) % 4;
               if (m_b < 0 && m_cur[m_j] != mt[m_j]) m_b = m_j;
            end
            if (m_b >= 0) begin
               m_d = mt[m_b] - m_cur[m_b];
               if (m_d > STEP)  m_d = STEP;
               if (m_d < -STEP) m_d = -STEP;
               m_cur[m_b] = m_cur[m_b] + m_d;
               m_req  = 1;
               m_band = m_b;
               m_val  = m_cur[m_b];
               m_rr   = (m_b + 1) % 4;
               log_band.push_back(m_b);
               log_val.push_back(m_cur[m_b]);
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("low_gain",  int'(low_gain),  m_cur[0]);
      chk("mid_gain",  int'(mid_gain),  m_cur[1]);
      chk("high_gain", int'(high_gain), m_cur[2]);
      chk("presence",  int'(presence),  m_cur[3]);
      chk("coef_req",  int'(coef_req),  int'(m_req));
      if (m_req) begin
         chk("coef_band", int'(coef_band), m_band);
         chk("coef_val",  int'(coef_val),  m_val);
      end
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("settled", int'(settled), int'(m_set));
   end

   // Ack driver: 0 = tied high, 1 = after ack_dly cycles of request, 2 = random.
   int ack_mode = 0;
   int ack_dly = 5;
   int req_cnt = 0;
   always @(posedge clk) begin
      #2;
      if (coef_req) req_cnt++; else req_cnt = 0;
      case (ack_mode)
         0:       coef_ack = 1'b1;
         1:       coef_ack = coef_req && (req_cnt >= ack_dly);
         default: coef_ack = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         sample_tick = 1'b1; step(1);
         sample_tick = 1'b0; step(gap - 1);
      end
   endtask

   task automatic clear_log();
      log_band.delete();
      log_val.delete();
   endtask

   task automatic set_all(input int v);
      low_tgt = W'(v); mid_tgt = W'(v); high_tgt = W'(v); pres_tgt = W'(v);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0; step(2); reset_n = 1'b1; step(1);
   endtask

   function automatic int qv(input int i);
      return (i < log_val.size()) ? log_val[i] : -1;
   endfunction

   function automatic int qb(input int i);
      return (i < log_band.size()) ? log_band[i] : -1;
   endfunction

   initial begin
      #1 reset_n = 1'b0;
      step(3);
      reset_n = 1'b1;
      step(2);
      chk("settled_after_reset", int'(settled), 1);
      ticks(4, 2);
      chk("idle_no_requests", log_val.size(), 0);
      chk("idle_low_gain", int'(low_gain), 64);

      // Single ramp of the low band with ack tied high.
      low_tgt = 7'd100;
      clear_log();
      ticks(12, 2);
      chk("ramp_steps", log_val.size(), 9);
      for (int i = 0; i < 9; i++) begin
         chk("ramp_val", qv(i), 68 + 4 * i);
         chk("ramp_band", qb(i), 0);
      end
      step(2);
      chk("ramp_final", int'(low_gain), 100);
      chk("ramp_settled", int'(settled), 1);

      // Round-robin across all four bands from a fresh reset.
      set_all(64);
      pulse_reset();
      set_all(80);
      clear_log();
      ticks(20, 2);
      chk("rr_steps", log_val.size(), 16);
      for (int i = 0; i < 16; i++) begin
         chk("rr_band", qb(i), i % 4);
         chk("rr_val", qv(i), 64 + 4 * (i / 4 + 1));
      end

      // Backpressure: ack after 5 request cycles, ticks every 3 cycles.
      ack_mode = 1;
      low_tgt = 7'd40;
      clear_log();
      m_ovr_cnt = 0;
      ticks(6, 3);
      step(10);
      chk("bp_steps", log_val.size(), 3);
      chk("bp_val0", qv(0), 76);
      chk("bp_val1", qv(1), 72);
      chk("bp_val2", qv(2), 68);
      chk("bp_overruns", m_ovr_cnt, 3);

      // Reversal mid-ramp clamps onto the new target.
      ack_mode = 0;
      reset_n = 1'b0;
      set_all(64);
      mid_tgt = 7'd90;
      step(2);
      reset_n = 1'b1;
      step(1);
      clear_log();
      ticks(2, 2);
      chk("rev_val0", qv(0), 68);
      chk("rev_val1", qv(1), 72);
      chk("rev_band", qb(1), 1);
      mid_tgt = 7'd70;
      ticks(4, 2);
      chk("rev_steps", log_val.size(), 3);
      chk("rev_clamp", qv(2), 70);
      chk("rev_mid_gain", int'(mid_gain), 70);

      // Reset while a request is outstanding.
      ack_mode = 1;
      mid_tgt = 7'd90;
      ticks(1, 1);
      step(1);
      chk("mreq_pending", int'(coef_req), 1);
      #1 reset_n = 1'b0;
      #1;
      chk("mreq_async_req", int'(coef_req), 0);
      chk("mreq_async_mid", int'(mid_gain), 64);
      step(1);
      reset_n = 1'b1;
      ack_mode = 0;
      step(1);
      clear_log();
      ticks(2, 2);
      chk("mreq_restart_band", qb(0), 1);
      chk("mreq_restart_val", qv(0), 68);

      // Random traffic with random acks and target changes.
      ack_mode = 2;
      for (int c = 0; c < 3000; c++) begin
         sample_tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 3))
               0: low_tgt  = W'($urandom_range(0, 127));
               1: mid_tgt  = W'($urandom_range(0, 127));
               2: high_tgt = W'($urandom_range(0, 127));
               default: pres_tgt = W'($urandom_range(0, 127));
            endcase
         end
         step(1);
      end
      sample_tick = 1'b0;
      ack_mode = 0;
      step(3);
      ticks(200, 2);
      step(2);
      chk("final_settled", int'(settled), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
